// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a non-showahead (1-cycle read latency) synchronous FIFO
// into a valid/ready stream through a 2-entry skid buffer.
// Optional packet framing on last_o is enabled by defining FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned PKT_LEN = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
);

    logic [DWIDTH-1:0] mem [2];
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic              head;
    logic              tail;
    logic              pend;
    logic              pop;

    // Stream outputs come straight from buffer registers
    assign valid_o = (cnt != 2'd0);
    assign data_o  = mem[head];

    // Handshake, next occupancy and read issue; reads only when the word fits after this cycle
    always_comb begin
        pop          = valid_o & ready_i;
        cnt_nxt      = cnt + 2'(pend) - 2'(pop);
        fifo_rdreq_o = rst_n_i & ~fifo_empty_i & (cnt_nxt < 2'd2);
    end

    // Skid buffer: capture the in-flight word, advance head on handshake
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt  <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
            pend <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pend <= fifo_rdreq_o;
            cnt  <= cnt_nxt;
            if (pend) begin
                mem[tail] <= fifo_q_i;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int unsigned        BEAT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0]  BEAT_MAX = BEAT_W'(PKT_LEN - 1);

    logic [BEAT_W-1:0] beat;

    // Beat position inside the current packet, advanced per handshake
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat <= '0;
        end else if (pop) begin
            beat <= (beat == BEAT_MAX) ? '0 : beat + BEAT_W'(1);
        end
    end

    assign last_o = valid_o & (beat == BEAT_MAX);
`else
    assign last_o = 1'b0;
`endif

    // Packet length must be at least one word
    a_pkt_len: assert property (@(posedge clk_i) PKT_LEN >= 1);

    // Buffered plus in-flight words never exceed the two buffer slots
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (3'(cnt) + 3'(pend)) <= 3'd2);

    // No read is ever issued against an empty FIFO
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(fifo_rdreq_o && fifo_empty_i));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: FIFO model and driver in one process,
// scoreboard monitor in another. Set FIFO_RD_STREAM_LAST_EN to check framing.
module tb_fifo_rd_stream;

    localparam int unsigned DW  = 16;
    localparam int unsigned PKT = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk_i;
    logic          rst_n_i;
    logic [DW-1:0] fifo_q_i;
    logic          fifo_empty_i;
    logic          fifo_rdreq_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;

    fifo_rd_stream #(.DWIDTH(DW), .PKT_LEN(PKT)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .fifo_q_i     (fifo_q_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdreq_o (fifo_rdreq_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem   [$];
    exp_t          exp_q [$];

    // driver-side bookkeeping
    logic rd = 1'b0;
    int   rd_n = 0, hs_n = 0, cyc_n = 0, hs_first = 0, hs_last = 0, last_n = 0;
    int   word_idx = 0;

    // monitor-side bookkeeping
    int            rd_seen = 0, hs_seen = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: word order, framing, hold rule, occupancy and underflow
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_n_i) begin
            rd_seen   = 0;
            hs_seen   = 0;
            prev_hold = 1'b0;
        end else begin
            check("rd_while_empty", 32'(fifo_rdreq_o & fifo_empty_i), 32'd0);
            check("occupancy_le_2", 32'((rd_seen - hs_seen) <= 2), 32'd1);
            if (prev_hold) begin
                check("hold_valid", 32'(valid_o), 32'd1);
                check("hold_data", 32'(data_o), 32'(prev_data));
                check("hold_last", 32'(last_o), 32'(prev_last));
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(data_o), 32'(e.d));
                    check("last", 32'(last_o), 32'(e.l));
                end
                hs_seen++;
            end
            if (fifo_rdreq_o) rd_seen++;
            prev_hold = valid_o & ~ready_i;
            prev_data = data_o;
            prev_last = last_o;
        end
    end

    // One clock: FIFO model reacts to last cycle's read, ready applied, then sample at negedge
    task automatic cyc(input logic rdy);
        @(posedge clk_i);
        #1;
        if (rd && rst_n_i) begin
            rd_n++;
            if (mem.size() != 0) fifo_q_i = mem.pop_front();
        end
        fifo_empty_i = (mem.size() == 0);
        ready_i      = rdy;
        @(negedge clk_i);
        cyc_n++;
        rd = fifo_rdreq_o;
        if (valid_o && ready_i) begin
            if (hs_n == 0) hs_first = cyc_n;
            hs_last = cyc_n;
            hs_n++;
            if (last_o) last_n++;
        end
    endtask

    // Push a word into the FIFO model and the expected stream
    task automatic load(input logic [DW-1:0] w);
        exp_t e;
        mem.push_back(w);
        e.d = w;
`ifdef FIFO_RD_STREAM_LAST_EN
        e.l = ((word_idx % PKT) == (PKT - 1));
`else
        e.l = 1'b0;
`endif
        word_idx++;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        fifo_empty_i = (mem.size() == 0);
        #1;
        rd = fifo_rdreq_o;
    endtask

    task automatic drain(input int budget, input bit rnd);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic release_rst();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        cyc_n++;
        rd = fifo_rdreq_o;
    endtask

    initial begin
        int r0;
        rst_n_i      = 1'b0;
        ready_i      = 1'b1;
        fifo_empty_i = 1'b1;
        fifo_q_i     = '0;

        // reset with FIFO non-empty
        repeat (2) @(negedge clk_i);
        load(16'h0055);
        settle();
        check("rst_rdreq", 32'(rd), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);

        release_rst();
        check("first_rdreq", 32'(rd), 32'd1);
        check("valid_t0", 32'(valid_o), 32'd0);
        cyc(1'b1);
        check("valid_t1", 32'(valid_o), 32'd0);
        cyc(1'b1);
        check("valid_t2", 32'(valid_o), 32'd1);
        check("data_t2", 32'(data_o), 32'h0055);
        drain(10, 1'b0);
        repeat (2) cyc(1'b1);

        // streaming 0x0001..0x0010 with ready held high
        hs_n = 0;
        r0   = rd_n;
        for (int i = 1; i <= 16; i++) load(DW'(i));
        settle();
        drain(100, 1'b0);
        repeat (3) cyc(1'b1);
        check("stream_rdreq_count", 32'(rd_n - r0), 32'd16);
        check("stream_hs_count", 32'(hs_n), 32'd16);
        check("stream_no_bubble", 32'(hs_last - hs_first), 32'd15);

        // single word with sink stalled
        cyc(1'b0);
        r0 = rd_n;
        load(16'hBEEF);
        settle();
        repeat (10) cyc(1'b0);
        check("one_word_rdreq", 32'(rd_n - r0), 32'd1);
        check("one_word_valid", 32'(valid_o), 32'd1);
        check("one_word_data", 32'(data_o), 32'hBEEF);
        drain(20, 1'b0);
        repeat (5) cyc(1'b1);
        check("empty_no_extra_rd", 32'(rd_n - r0), 32'd1);

        // random back-pressure over 200 words
        for (int i = 0; i < 200; i++) load(DW'($urandom));
        settle();
        drain(3000, 1'b1);
        repeat (3) cyc(1'b1);

        // reset with the buffer full and FIFO still holding words
        cyc(1'b0);
        for (int i = 0; i < 6; i++) load(16'h7700 + DW'(i));
        settle();
        repeat (5) cyc(1'b0);
        check("pre_reset_valid", 32'(valid_o), 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_data", 32'(data_o), 32'd0);
        check("mid_rst_last", 32'(last_o), 32'd0);
        check("mid_rst_rdreq", 32'(fifo_rdreq_o), 32'd0);
        mem.delete();
        exp_q.delete();
        word_idx     = 0;
        fifo_empty_i = 1'b1;
        rd           = 1'b0;
        repeat (2) cyc(1'b1);
        release_rst();
        check("post_rst_valid", 32'(valid_o), 32'd0);
        check("post_rst_rdreq", 32'(rd), 32'd0);

        // framing: 12 fresh words after reset
        last_n = 0;
        for (int i = 0; i < 12; i++) load(16'hA001 + DW'(i));
        settle();
        drain(100, 1'b0);
`ifdef FIFO_RD_STREAM_LAST_EN
        check("last_count", 32'(last_n), 32'd3);
`else
        check("last_count", 32'(last_n), 32'd0);
`endif
        repeat (3) cyc(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
